// File: rtl/avg_frame_loader.sv
// Serial-to-parallel frame loader feeding the eight-input averager.
// Optional running sum of the frame samples when AVG_FRAME_SUM_EN is defined.
//
// state | meaning
// FILL  | accepting samples into slot[idx]; in_ready high
// HOLD  | complete frame presented on a..h/sa; waiting for frame_ready
module avg_frame_loader #(
  parameter int DATAWIDTH   = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [DATAWIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             sa_cfg,
  input  logic                   flush,
  output logic [DATAWIDTH-1:0]   a,
  output logic [DATAWIDTH-1:0]   b,
  output logic [DATAWIDTH-1:0]   c,
  output logic [DATAWIDTH-1:0]   d,
  output logic [DATAWIDTH-1:0]   e,
  output logic [DATAWIDTH-1:0]   f,
  output logic [DATAWIDTH-1:0]   g,
  output logic [DATAWIDTH-1:0]   h,
  output logic [7:0]             sa,
  output logic                   frame_valid,
  input  logic                   frame_ready,
`ifdef AVG_FRAME_SUM_EN
  output logic [DATAWIDTH+15:0]  sum,
`endif
  output logic [FRAME_CNT_W-1:0] frames_done
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state, state_nxt;
  logic [2:0]           idx;
  logic [DATAWIDTH-1:0] slot [8];
  logic                 accept;
  logic                 handoff;

  // in_ready must drop with Rst itself, not just on the next edge
  assign in_ready    = (state == FILL) && !Rst;
  assign frame_valid = (state == HOLD);
  assign accept      = in_valid && in_ready && !flush;
  assign handoff     = (state == HOLD) && frame_ready && !flush;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: if (accept && idx == 3'd7) state_nxt = HOLD;
        HOLD: if (frame_ready)           state_nxt = FILL;
        default:                         state_nxt = FILL;
      endcase
    end
  end

  // flush rewinds the index only; slot contents and sa are deliberately kept
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      idx <= 3'd0;
      sa  <= 8'd0;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
    end else if (flush) begin
      idx <= 3'd0;
    end else if (accept) begin
      slot[idx] <= in_data;
      idx       <= idx + 3'd1;
      if (idx == 3'd0) sa <= sa_cfg;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)          frames_done <= '0;
    else if (handoff) frames_done <= frames_done + 1'b1;
  end

`ifdef AVG_FRAME_SUM_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)         sum <= '0;
    else if (flush)  sum <= '0;
    else if (accept) begin
      if (idx == 3'd0) sum <= {16'd0, in_data};
      else             sum <= sum + {16'd0, in_data};
    end
  end
`endif

  assign a = slot[0];
  assign b = slot[1];
  assign c = slot[2];
  assign d = slot[3];
  assign e = slot[4];
  assign f = slot[5];
  assign g = slot[6];
  assign h = slot[7];

endmodule

// File: tb/tb_avg_frame_loader.sv
// Directed self-checking bench for avg_frame_loader; a second instance with
// a 2-bit frame counter shares the stimulus to exercise counter wrap.
module tb_avg_frame_loader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [7:0]  sa_cfg;
  logic        flush;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [15:0] a2, b2, c2, d2, e2, f2, g2, h2;
  logic [7:0]  sa, sa2;
  logic        frame_valid, frame_valid2;
  logic        frame_ready;
  logic [15:0] frames_done;
  logic [1:0]  frames_done2;
`ifdef AVG_FRAME_SUM_EN
  logic [31:0] sum, sum2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  avg_frame_loader #(.DATAWIDTH(16), .FRAME_CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sa_cfg(sa_cfg), .flush(flush),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .sa(sa), .frame_valid(frame_valid), .frame_ready(frame_ready),
`ifdef AVG_FRAME_SUM_EN
    .sum(sum),
`endif
    .frames_done(frames_done)
  );

  avg_frame_loader #(.DATAWIDTH(16), .FRAME_CNT_W(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .sa_cfg(sa_cfg), .flush(flush),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2), .h(h2),
    .sa(sa2), .frame_valid(frame_valid2), .frame_ready(frame_ready),
`ifdef AVG_FRAME_SUM_EN
    .sum(sum2),
`endif
    .frames_done(frames_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [15:0] dat, input logic [7:0] s);
    in_valid = 1'b1;
    in_data  = dat;
    sa_cfg   = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handoff();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; in_data = '0; in_valid = 1'b0; sa_cfg = '0;
    flush = 1'b0; frame_ready = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_frames_done", frames_done, 0);
    #9 Rst = 1'b0;   // release between edges
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Back-to-back frame 1..8, sa_cfg = 3
    for (int i = 1; i <= 7; i++) send(16'(i), 8'd3);
    chk("t1_not_yet_valid", frame_valid, 0);
    send(16'd8, 8'd3);
    chk("t1_frame_valid", frame_valid, 1);
    chk("t1_a", a, 1);
    chk("t1_d", d, 4);
    chk("t1_h", h, 8);
    chk("t1_sa", sa, 3);
    chk("t1_in_ready", in_ready, 0);
`ifdef AVG_FRAME_SUM_EN
    chk("t1_sum", sum, 36);
`endif

    // HOLD ignores input; then handoff
    in_valid = 1'b1; in_data = 16'hFFFF;
    repeat (5) tick();
    in_valid = 1'b0;
    chk("t2_hold_a", a, 1);
    chk("t2_hold_h", h, 8);
    chk("t2_hold_in_ready", in_ready, 0);
    chk("t2_hold_valid", frame_valid, 1);
    chk("t2_hold_cnt", frames_done, 0);
    handoff();
    chk("t2_valid_low", frame_valid, 0);
    chk("t2_frames_done", frames_done, 1);
    chk("t2_in_ready", in_ready, 1);
    handoff();   // no frame present: no effect
    chk("t2_idle_ready_cnt", frames_done, 1);

    // flush after 3 accepts, with a simultaneous sample
    send(16'h20, 8'd5); send(16'h21, 8'd5); send(16'h22, 8'd5);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_flush_valid", frame_valid, 0);
    chk("t3_flush_a_kept", a, 16'h20);
    chk("t3_flush_d_not_written", d, 4);
    chk("t3_flush_cnt", frames_done, 1);
`ifdef AVG_FRAME_SUM_EN
    chk("t3_flush_sum", sum, 0);
`endif
    for (int i = 0; i < 8; i++) send(16'(16'h10 + i), 8'd7);
    chk("t3_frame_valid", frame_valid, 1);
    chk("t3_a", a, 16'h10);
    chk("t3_h", h, 16'h17);
    chk("t3_sa", sa, 7);
    chk("t3_cnt", frames_done, 1);
`ifdef AVG_FRAME_SUM_EN
    chk("t3_sum", sum, 156);
`endif
    handoff();
    chk("t3_handoff_cnt", frames_done, 2);

    // Async reset mid-frame
    for (int i = 0; i < 5; i++) send(16'(16'h30 + i), 8'd9);
    #3 Rst = 1'b1;
    #1;
    chk("t4_rst_a", a, 0);
    chk("t4_rst_sa", sa, 0);
    chk("t4_rst_in_ready", in_ready, 0);
    chk("t4_rst_cnt", frames_done, 0);
    chk("t4_rst_cnt2", frames_done2, 0);
    #8 Rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) send(16'hFFFF, 8'd1);
    chk("t4_frame_valid", frame_valid, 1);
    chk("t4_a", a, 16'hFFFF);
    chk("t4_h", h, 16'hFFFF);
`ifdef AVG_FRAME_SUM_EN
    chk("t4_sum", sum, 32'h7FFF8);
`endif
    handoff();
    chk("t4_cnt", frames_done, 1);

    // Toggling in_valid, sa_cfg changing every cycle
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 16'(i);
      sa_cfg   = 8'(8'h40 + i);
      if (i == 14) chk("t5_pre_valid", frame_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_frame_valid", frame_valid, 1);
    chk("t5_sa", sa, 8'h40);
    chk("t5_a", a, 0);
    chk("t5_e", e, 8);
    chk("t5_h", h, 14);
    handoff();
    chk("t5_cnt", frames_done, 2);

    // Counter wrap on the 2-bit instance: 1,2,3,0,1
    Rst = 1'b1;
    #2 Rst = 1'b0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 8; i++) send(16'(k * 8 + i), 8'(k));
      handoff();
      chk("t6_cnt2", frames_done2, 32'(k % 4));
      chk("t6_cnt16", frames_done, 32'(k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avg_frame_loader.md
Name: avg_frame_loader

Overview:
- Producer side of the eight-input averaging datapath: collects a serial stream of 16-bit samples into an 8-slot frame and presents them in parallel as a..h, together with the shift amount sa.
- Uses a valid/ready handshake on both the sample input and the frame output.
- Converts a one-sample-per-cycle source into the parallel operand set the averager consumes.

Parameters:
- DATAWIDTH, 16, width of each sample and of outputs a..h
- FRAME_CNT_W, 16, width of the completed-frame counter

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- in_data  input  DATAWIDTH  sample value
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a sample
- sa_cfg  input  8  shift amount to attach to the frame being filled
- flush  input  1  synchronous abort of the current frame
- a,b,c,d,e,f,g,h  output  DATAWIDTH  frame slots 0..7 (a = first accepted sample)
- sa  output  8  shift amount latched for the current frame
- frame_valid  output  1  a..h and sa hold a complete frame
- frame_ready  input  1  consumer takes the frame
- frames_done  output  FRAME_CNT_W  count of frames handed off

Behaviour:
- Interface: one clock, Clk. Reset Rst is asynchronous and active-high.
- Reset values:
  - state = FILL, slot index = 0.
  - a..h = 0, sa = 0, frame_valid = 0, frames_done = 0.
  - in_ready = 0 while Rst is high; in_ready = 1 in the first cycle after Rst deasserts.
- States: FILL, HOLD.
- in_ready = (state == FILL) && !Rst. Combinational from state, with no dependency on in_valid.
- Accept = in_valid && in_ready, sampled at the rising edge.
- FILL:
  - Each accept writes in_data to slot[idx] and increments idx.
  - On the accept with idx == 0, sa_cfg is latched into sa.
  - On the accept with idx == 7: idx wraps to 0, state -> HOLD, and frame_valid = 1 from the next cycle.
  - Latency from the 8th accept edge to frame_valid high is 1 cycle.
- HOLD:
  - a..h and sa are stable and in_ready = 0; in_valid is ignored.
  - frame_ready sampled high -> frame_valid = 0 next cycle, frames_done increments, state -> FILL.
  - A new sample can be accepted in the cycle after the handoff edge, giving a minimum frame period of 9 cycles.
  - frame_ready asserted while frame_valid = 0 has no effect.
- flush (sampled high):
  - Highest priority after Rst: idx = 0, frame_valid = 0, state -> FILL.
  - frames_done is not incremented.
  - Slot registers and sa keep their old values (not cleared).
  - A simultaneous accept or frame_ready in the same cycle is discarded.
- frames_done wraps from 2^FRAME_CNT_W-1 to 0 with no flag.
- Slot values are stored unmodified; no arithmetic on samples in the base configuration.
- Rst asserted mid-frame: immediate return to reset values; partial frame lost.
- Gaps in in_valid during FILL are allowed and impose no timeout.

Optional Feature:
- Macro: AVG_FRAME_SUM_EN.
- Defined:
  - Adds output sum[DATAWIDTH+15:0] (32 bits at default), a running accumulator.
  - sum is zeroed at the idx == 0 accept, then sum = sum + {16'd0, in_data} on each accept. The first accept loads in_data directly.
  - sum is held through HOLD, so when frame_valid = 1, sum == a+b+...+h, zero-extended, with no overflow at default widths.
  - Reset value 0. flush clears sum to 0.
- Undefined: the sum port and its accumulator are absent; all other behaviour is identical.

Test Plan:
- Reset then 8 back-to-back accepts of 1,2,...,8 with sa_cfg = 3 -> frame_valid high exactly 1 cycle after the 8th edge; a=1 ... h=8, sa=3, in_ready=0; with AVG_FRAME_SUM_EN, sum=36.
- Hold frame_ready = 0 for 5 cycles while in_valid = 1 with data 0xFFFF -> a..h unchanged and in_ready = 0; then frame_ready = 1 for one cycle -> frame_valid low next cycle, frames_done=1, in_ready=1.
- Accept 3 samples, then flush together with in_valid = 1 -> the 4th sample is not written; the next 8 accepts 0x10..0x17 form a frame with a=0x10, h=0x17; frames_done unchanged by the flush.
- Assert Rst asynchronously (between edges) after 5 accepts -> outputs go to reset values immediately without waiting for an edge; after release, a full 8-sample frame with all samples 0xFFFF gives a..h=0xFFFF and sum=0x7FFF8 with AVG_FRAME_SUM_EN.
- in_valid toggling 1,0,1,0,... with sa_cfg changing every cycle -> frame completes after 8 accepts; sa equals the sa_cfg value present at the first accept.
- With FRAME_CNT_W = 2, complete 5 frames -> frames_done sequence 1,2,3,0,1.
